// File: rtl/ifetch_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : ifetch_ctrl_if
//  Description : Bus bundle for the instruction-fetch sequencer.
//                Carries the combinational instruction-memory read port
//                (imem_addr out, imem_instr back) and the valid/ready fetch
//                queue head toward decode (out_valid/out_instr/out_pc out,
//                out_ready back).
//                  master : fetch sequencer side (drives address and queue head)
//                  slave  : memory/decode side (drives instruction word and ready)
//  Revision    : 1.0  initial release
// ============================================================================
interface ifetch_ctrl_if;
   logic [63:0] imem_addr;
   logic [31:0] imem_instr;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instr;
   logic [63:0] out_pc;

   modport master (
      output imem_addr,
      input  imem_instr,
      output out_valid,
      input  out_ready,
      output out_instr,
      output out_pc
   );

   modport slave (
      input  imem_addr,
      output imem_instr,
      input  out_valid,
      output out_ready,
      input  out_instr,
      input  out_pc
   );
endinterface
`default_nettype wire

// File: rtl/ifetch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : ifetch_ctrl
//  Description : Instruction-fetch sequencer. Owns the PC, presents it to a
//                combinational instruction memory and buffers {pc, word}
//                pairs in a small FIFO drained by decode over valid/ready.
//                Redirects flush the queue and reload the PC; running past
//                the end of instruction memory parks the fetcher in FAULT.
//  Ports       : clk, reset           clock / synchronous active-high reset
//                bus (master)         imem read port + decode queue head
//                fetch_en             1 = fetching allowed, 0 = hold PC
//                redirect_valid/_pc   taken branch / jump target
//                fault                PC out of range, fetch stopped
//                trap_valid/trap_pc   misaligned-redirect trap (optional)
//  Options     : `define IFETCH_MISALIGN_TRAP_EN to trap misaligned redirect
//                targets instead of silently aligning them.
//  Revision    : 1.0  initial release
// ============================================================================
module ifetch_ctrl #(
   parameter logic [63:0] RESET_PC   = 64'h0,
   parameter int          FQ_DEPTH   = 2,
   parameter int          IMEM_WORDS = 1024
) (
   input  logic          clk,
   input  logic          reset,
   ifetch_ctrl_if.master bus,
   input  logic          fetch_en,
   input  logic          redirect_valid,
   input  logic [63:0]   redirect_pc,
`ifdef IFETCH_MISALIGN_TRAP_EN
   output logic          trap_valid,
   output logic [63:0]   trap_pc,
`endif
   output logic          fault
);

   localparam int PTR_W = $clog2(FQ_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   localparam logic [CNT_W-1:0] c_depth      = CNT_W'(FQ_DEPTH);
   localparam logic [61:0]      c_imem_words = 62'(IMEM_WORDS);

   localparam logic [1:0] c_st_idle  = 2'd0;
   localparam logic [1:0] c_st_run   = 2'd1;
   localparam logic [1:0] c_st_fault = 2'd2;

   // ------------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------------
   logic [1:0]       state_q,  state_d;
   logic [63:0]      pc_q,     pc_d;
   logic [CNT_W-1:0] count_q,  count_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [63:0]      fq_pc_q    [FQ_DEPTH];
   logic [63:0]      fq_pc_d    [FQ_DEPTH];
   logic [31:0]      fq_instr_q [FQ_DEPTH];
   logic [31:0]      fq_instr_d [FQ_DEPTH];
`ifdef IFETCH_MISALIGN_TRAP_EN
   logic             trap_valid_q, trap_valid_d;
   logic [63:0]      trap_pc_q,    trap_pc_d;
`endif

   // ------------------------------------------------------------------------
   // Shared combinational terms
   // ------------------------------------------------------------------------
   logic        pc_in_range;
   logic        target_in_range;
   logic [63:0] redir_target;
   logic        misalign_trap;
   logic        pop;
   logic        fetch_go;
   logic        push;

   assign pc_in_range     = (pc_q[63:2] < c_imem_words);
   // Low address bits never reach the PC: either the redirect traps or the
   // target is forced word-aligned.
   assign redir_target    = {redirect_pc[63:2], 2'b00};
   assign target_in_range = (redir_target[63:2] < c_imem_words);
   assign pop             = (count_q != '0) && bus.out_ready;

`ifdef IFETCH_MISALIGN_TRAP_EN
   assign misalign_trap = redirect_valid && (redirect_pc[1:0] != 2'b00);
`else
   assign misalign_trap = 1'b0;
`endif

   // ------------------------------------------------------------------------
   // FSM: state register (also holds the datapath flops)
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= c_st_idle;
         pc_q     <= RESET_PC;
         count_q  <= '0;
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         for (int i = 0; i < FQ_DEPTH; i++) begin
            fq_pc_q[i]    <= '0;
            fq_instr_q[i] <= '0;
         end
`ifdef IFETCH_MISALIGN_TRAP_EN
         trap_valid_q <= 1'b0;
         trap_pc_q    <= '0;
`endif
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         count_q    <= count_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         fq_pc_q    <= fq_pc_d;
         fq_instr_q <= fq_instr_d;
`ifdef IFETCH_MISALIGN_TRAP_EN
         trap_valid_q <= trap_valid_d;
         trap_pc_q    <= trap_pc_d;
`endif
      end
   end

   // ------------------------------------------------------------------------
   // FSM: next-state logic. A redirect overrides every state transition.
   // ------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      if (redirect_valid) begin
         if (misalign_trap || !target_in_range) begin
            state_d = c_st_fault;
         end else if (fetch_en) begin
            state_d = c_st_run;
         end else begin
            state_d = c_st_idle;
         end
      end else begin
         case (state_q)
            c_st_idle: begin
               if (fetch_en) state_d = c_st_run;
            end
            c_st_run: begin
               if (!fetch_en) begin
                  state_d = c_st_idle;
               end else if (!pc_in_range) begin
                  state_d = c_st_fault;
               end
            end
            c_st_fault: state_d = c_st_fault;
            default:    state_d = c_st_idle;
         endcase
      end
   end

   // ------------------------------------------------------------------------
   // FSM: outputs and fetch enables
   // ------------------------------------------------------------------------
   always_comb begin
      fault    = (state_q == c_st_fault);
      fetch_go = (state_q == c_st_run) && fetch_en && pc_in_range && !redirect_valid;
      // A full queue can still accept the new word when the head leaves
      // on the same edge.
      push     = fetch_go && ((count_q != c_depth) || pop);
   end

   // ------------------------------------------------------------------------
   // Datapath: PC sequencing and fetch queue
   // ------------------------------------------------------------------------
   always_comb begin
      pc_d       = pc_q;
      count_d    = count_q;
      rd_ptr_d   = rd_ptr_q;
      wr_ptr_d   = wr_ptr_q;
      fq_pc_d    = fq_pc_q;
      fq_instr_d = fq_instr_q;
      if (redirect_valid) begin
         // Any same-cycle pop is already accepted by decode; the flush
         // simply discards whatever remains.
         count_d  = '0;
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         if (!misalign_trap) pc_d = redir_target;
      end else begin
         if (push) begin
            fq_pc_d[wr_ptr_q]    = pc_q;
            fq_instr_d[wr_ptr_q] = bus.imem_instr;
            wr_ptr_d             = wr_ptr_q + PTR_W'(1);
            pc_d                 = pc_q + 64'd4;
         end
         if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
         count_d = count_q + CNT_W'(push) - CNT_W'(pop);
      end
   end

`ifdef IFETCH_MISALIGN_TRAP_EN
   always_comb begin
      trap_valid_d = misalign_trap;
      trap_pc_d    = misalign_trap ? redirect_pc : trap_pc_q;
   end

   assign trap_valid = trap_valid_q;
   assign trap_pc    = trap_pc_q;
`endif

   // ------------------------------------------------------------------------
   // Bus outputs; queue head is forced to zero when empty
   // ------------------------------------------------------------------------
   assign bus.imem_addr = pc_q;
   assign bus.out_valid = (count_q != '0);
   assign bus.out_instr = (count_q != '0) ? fq_instr_q[rd_ptr_q] : 32'd0;
   assign bus.out_pc    = (count_q != '0) ? fq_pc_q[rd_ptr_q]    : 64'd0;

endmodule
`default_nettype wire

// File: tb/tb_ifetch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ifetch_ctrl
//  Description : Self-checking bench for ifetch_ctrl. A directed sequence
//                followed by randomized fetch_en / out_ready / redirect /
//                reset stimulus; every cycle the DUT outputs are compared to
//                a queue-based reference model. Instruction memory returns
//                the word index (mem[i] = i).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ifetch_ctrl;

   localparam logic [63:0] RESET_PC   = 64'h0;
   localparam int          FQ_DEPTH   = 2;
   localparam int          IMEM_WORDS = 1024;
`ifdef IFETCH_MISALIGN_TRAP_EN
   localparam bit          TRAP_EN    = 1'b1;
`else
   localparam bit          TRAP_EN    = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic        fetch_en;
   logic        redirect_valid;
   logic [63:0] redirect_pc;
   logic        fault;
`ifdef IFETCH_MISALIGN_TRAP_EN
   logic        trap_valid;
   logic [63:0] trap_pc;
`endif

   ifetch_ctrl_if bus ();

   // Combinational instruction memory: word i holds value i.
   assign bus.imem_instr = bus.imem_addr[33:2];

   ifetch_ctrl #(
      .RESET_PC   (RESET_PC),
      .FQ_DEPTH   (FQ_DEPTH),
      .IMEM_WORDS (IMEM_WORDS)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .bus            (bus),
      .fetch_en       (fetch_en),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
`ifdef IFETCH_MISALIGN_TRAP_EN
      .trap_valid     (trap_valid),
      .trap_pc        (trap_pc),
`endif
      .fault          (fault)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   int seen_fault  = 0;
   int seen_stall  = 0;

   // ------------------------------------------------------------------------
   // Reference model: mode, PC and a queue of fetched PCs (word = pc>>2).
   // ------------------------------------------------------------------------
   localparam int M_IDLE  = 0;
   localparam int M_RUN   = 1;
   localparam int M_FAULT = 2;

   int          m_mode;
   logic [63:0] m_pc;
   logic [63:0] m_q[$];
   logic        m_trap_v;
   logic [63:0] m_trap_pc;

   function automatic bit in_range(input logic [63:0] a);
      return (a >> 2) < 64'(IMEM_WORDS);
   endfunction

   task automatic model_edge();
      logic [63:0] tgt;
      if (reset) begin
         m_mode    = M_IDLE;
         m_pc      = RESET_PC;
         m_q.delete();
         m_trap_v  = 1'b0;
         m_trap_pc = '0;
         return;
      end
      m_trap_v = 1'b0;
      if (redirect_valid) begin
         m_q.delete();
         if (TRAP_EN && redirect_pc[1:0] != 2'b00) begin
            m_mode    = M_FAULT;
            m_trap_v  = 1'b1;
            m_trap_pc = redirect_pc;
         end else begin
            tgt  = redirect_pc & ~64'h3;
            m_pc = tgt;
            if (!in_range(tgt))  m_mode = M_FAULT;
            else if (fetch_en)   m_mode = M_RUN;
            else                 m_mode = M_IDLE;
         end
         return;
      end
      if (m_q.size() > 0 && bus.out_ready) void'(m_q.pop_front());
      case (m_mode)
         M_IDLE: if (fetch_en) m_mode = M_RUN;
         M_RUN: begin
            if (!fetch_en)             m_mode = M_IDLE;
            else if (!in_range(m_pc))  m_mode = M_FAULT;
            else if (m_q.size() < FQ_DEPTH) begin
               m_q.push_back(m_pc);
               m_pc = m_pc + 64'd4;
            end else begin
               seen_stall++;
            end
         end
         default: ;
      endcase
   endtask

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic compare_all();
      logic [63:0] e_pc;
      logic [31:0] e_instr;
      e_pc    = (m_q.size() > 0) ? m_q[0] : 64'd0;
      e_instr = e_pc[33:2];
      check_eq("out_valid", 64'(bus.out_valid), 64'(m_q.size() > 0));
      check_eq("out_pc",    bus.out_pc,         e_pc);
      check_eq("out_instr", 64'(bus.out_instr), 64'(e_instr));
      check_eq("imem_addr", bus.imem_addr,      m_pc);
      check_eq("fault",     64'(fault),         64'(m_mode == M_FAULT));
`ifdef IFETCH_MISALIGN_TRAP_EN
      check_eq("trap_valid", 64'(trap_valid), 64'(m_trap_v));
      check_eq("trap_pc",    trap_pc,         m_trap_pc);
`endif
      if (m_mode == M_FAULT) seen_fault++;
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
      compare_all();
   endtask

   task automatic drive(input logic rst_i, input logic en_i, input logic rdy_i,
                        input logic rv_i, input logic [63:0] rpc_i);
      reset          = rst_i;
      fetch_en       = en_i;
      bus.out_ready  = rdy_i;
      redirect_valid = rv_i;
      redirect_pc    = rpc_i;
   endtask

   task automatic run(input int n, input logic en_i, input logic rdy_i);
      for (int i = 0; i < n; i++) begin
         drive(1'b0, en_i, rdy_i, 1'b0, 64'h0);
         tick();
      end
   endtask

   task automatic redir(input logic [63:0] tgt, input logic en_i, input logic rdy_i);
      drive(1'b0, en_i, rdy_i, 1'b1, tgt);
      tick();
   endtask

   function automatic logic [63:0] pick_target();
      logic [63:0] r;
      case ($urandom_range(0, 7))
         0: r = 64'h0;
         1: r = 64'h40;
         2: r = 64'hFF8;
         3: r = 64'hFFC;
         4: r = 64'h1000;
         5: r = 64'h42;
         6: r = 64'({$urandom_range(0, IMEM_WORDS - 1), 2'b00});
         default: r = {$urandom, $urandom};
      endcase
      return r;
   endfunction

   initial begin
      drive(1'b1, 1'b0, 1'b0, 1'b0, 64'h0);
      tick();
      tick();

      // Streaming from reset with decode always ready.
      run(10, 1'b1, 1'b1);
      // Back-pressure: queue fills, PC stalls, then resumes without loss.
      run(6, 1'b1, 1'b0);
      run(4, 1'b1, 1'b1);
      // Redirect while full with the head accepted the same cycle.
      run(4, 1'b1, 1'b0);
      redir(64'h40, 1'b1, 1'b1);
      run(4, 1'b1, 1'b1);
      // Run off the end of memory, drain, then recover.
      redir(64'hFF8, 1'b1, 1'b1);
      run(8, 1'b1, 1'b1);
      redir(64'h0, 1'b1, 1'b1);
      run(4, 1'b1, 1'b1);
      // Misaligned redirect target.
      redir(64'h42, 1'b1, 1'b1);
      run(4, 1'b1, 1'b1);
      redir(64'h0, 1'b1, 1'b1);
      // Redirect with fetch disabled goes idle.
      redir(64'h80, 1'b0, 1'b1);
      run(3, 1'b0, 1'b1);
      run(4, 1'b1, 1'b0);
      // Mid-stream reset with a full queue.
      drive(1'b1, 1'b1, 1'b0, 1'b0, 64'h0);
      tick();
      run(4, 1'b1, 1'b1);

      // Randomized phase.
      for (int i = 0; i < 4000; i++) begin
         drive(($urandom_range(0, 199) == 0),
               ($urandom_range(0, 99) < 85),
               ($urandom_range(0, 99) < 60),
               ($urandom_range(0, 99) < 8),
               pick_target());
         tick();
      end

      check_eq("fault_reached", 64'(seen_fault > 0), 64'd1);
      check_eq("stall_reached", 64'(seen_stall > 0), 64'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
